// File: rtl/gate_unit_arbiter_if.sv
// Request/response bundle between NREQ requesters, the shared logic unit scheduler and one consumer.
interface gate_unit_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W    = 8
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [2*NREQ-1:0] req_op;
  logic [W*NREQ-1:0] req_a;
  logic [W*NREQ-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_y;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_y
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_y
  );
endinterface

// File: rtl/gate_unit_arbiter.sv
// Round-robin scheduler for a shared mux-based bitwise unit; one accept per cycle,
// result registered (1 cycle) into a 1-deep buffer that stalls grants while held.
module gate_unit_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  gate_unit_arbiter_if.slave bus
);
  localparam int IDW = $clog2(NREQ);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [IDW-1:0]  ptr, ptr_nxt;
  logic [IDW-1:0]  id_q, id_nxt;
  logic [W-1:0]    y_q, y_nxt;
  logic [IDW-1:0]  grant;
  logic            grant_vld;
  logic            accept;
  logic [NREQ-1:0] ready;
  logic [1:0]      op;
  logic [W-1:0]    a, b, y0, y1, f;

  // Search starts at ptr and wraps; first valid requester found wins.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (int'(ptr) + k) % NREQ;
      if (!grant_vld && bus.req_valid[idx]) begin
        grant_vld = 1'b1;
        grant     = IDW'(idx);
      end
    end
  end

  always_comb begin
    op = bus.req_op[2*grant +: 2];
    a  = bus.req_a[W*grant +: W];
    b  = bus.req_b[W*grant +: W];
    y0 = '0;
    y1 = '0;
    case (op)
      2'b00:   begin y0 = '0; y1 = b;  end
      2'b01:   begin y0 = b;  y1 = '1; end
      2'b10:   begin y0 = b;  y1 = ~b; end
      default: begin y0 = ~b; y1 = b;  end
    endcase
    f = (a & y1) | (~a & y0);
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    y_nxt     = y_q;
    id_nxt    = id_q;
    ready     = '0;
    accept    = !rst && grant_vld && ((state == EMPTY) || bus.rsp_ready);
    if (accept) ready[grant] = 1'b1;
    case (state)
      EMPTY: begin
        if (accept) state_nxt = FULL;
      end
      FULL: begin
        if (bus.rsp_ready && !accept) state_nxt = EMPTY;
      end
      default: state_nxt = EMPTY;
    endcase
    if (accept) begin
      y_nxt   = f;
      id_nxt  = grant;
      ptr_nxt = IDW'((int'(grant) + 1) % NREQ);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      ptr   <= '0;
      y_q   <= '0;
      id_q  <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      y_q   <= y_nxt;
      id_q  <= id_nxt;
    end
  end

  assign bus.req_ready = ready;
  assign bus.rsp_valid = (state == FULL);
  assign bus.rsp_id    = id_q;
  assign bus.rsp_y     = y_q;
endmodule

// File: tb/tb_gate_unit_arbiter.sv
// Randomized and directed bench for gate_unit_arbiter against a cycle-level behavioural model.
module tb_gate_unit_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gate_unit_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();
  gate_unit_arbiter #(.NREQ(NREQ), .W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  logic         m_vld;
  logic [W-1:0] m_y;
  int           m_id;
  int           m_ptr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_f(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return ~(a ^ b);
    endcase
  endfunction

  function automatic int ref_grant(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++)
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  task automatic set_req(input int i, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.req_op[2*i +: 2] = op;
    bus.req_a[W*i +: W]  = a;
    bus.req_b[W*i +: W]  = b;
  endtask

  // Called just after a negedge with inputs settled: checks, advances one clock, updates the model.
  task automatic step(input string tag);
    int              g;
    bit              acc;
    logic [NREQ-1:0] exp_rdy;
    #1;
    g       = ref_grant(bus.req_valid, m_ptr);
    acc     = !rst && (g >= 0) && (!m_vld || bus.rsp_ready);
    exp_rdy = '0;
    if (acc) exp_rdy[g] = 1'b1;
    check({tag, "/rdy"}, 32'(bus.req_ready), 32'(exp_rdy));
    check({tag, "/vld"}, 32'(bus.rsp_valid), 32'(m_vld));
    check({tag, "/id"},  32'(bus.rsp_id),    32'(m_id));
    check({tag, "/y"},   32'(bus.rsp_y),     32'(m_y));
    @(posedge clk);
    if (rst) begin
      m_vld = 1'b0; m_y = '0; m_id = 0; m_ptr = 0;
    end else if (acc) begin
      m_vld = 1'b1;
      m_y   = ref_f(bus.req_op[2*g +: 2], bus.req_a[W*g +: W], bus.req_b[W*g +: W]);
      m_id  = g;
      m_ptr = (g + 1) % NREQ;
    end else if (bus.rsp_ready) begin
      m_vld = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic post(input string tag, input int id, input logic [W-1:0] y);
    #1;
    check({tag, "/vld_k"}, 32'(bus.rsp_valid), 32'd1);
    check({tag, "/id_k"},  32'(bus.rsp_id),    32'(id));
    check({tag, "/y_k"},   32'(bus.rsp_y),     32'(y));
  endtask

  logic [W-1:0] sweep_exp [4];
  int           fair_exp  [6];

  initial begin
    sweep_exp = '{8'h88, 8'hEE, 8'h66, 8'h99};
    fair_exp  = '{0, 1, 2, 3, 0, 1};
    rst = 1'b1;
    bus.req_valid = '0; bus.req_op = '0; bus.req_a = '0; bus.req_b = '0;
    bus.rsp_ready = 1'b0;
    m_vld = 1'b0; m_y = '0; m_id = 0; m_ptr = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.req_valid = '1;
    step("reset");

    // single request
    rst = 1'b0; bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b0100;
    set_req(2, 2'b10, 8'hA5, 8'h0F);
    step("single");
    bus.req_valid = '0;
    post("single", 2, 8'hAA);
    step("single_out");

    // opcode sweep, back-to-back on requester 0
    bus.req_valid = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      set_req(0, 2'(k), 8'hCC, 8'hAA);
      step("sweep");
      post("sweep", 0, sweep_exp[k]);
    end
    bus.req_valid = '0;
    step("sweep_end");

    // fairness from ptr=0
    rst = 1'b1; step("rst2"); rst = 1'b0;
    bus.req_valid = '1;
    for (int k = 0; k < NREQ; k++) set_req(k, 2'(k), 8'(8'h11 * (k + 1)), 8'h5A);
    for (int k = 0; k < 6; k++) begin
      step("fair");
      post("fair", fair_exp[k], ref_f(2'(fair_exp[k]), 8'(8'h11 * (fair_exp[k] + 1)), 8'h5A));
    end

    // ptr is 2 after the grant to 1: 3 wins before 0
    bus.req_valid = 4'b1001;
    step("ptr_a"); post("ptr_a", 3, ref_f(2'd3, 8'h44, 8'h5A));
    step("ptr_b"); post("ptr_b", 0, ref_f(2'd0, 8'h11, 8'h5A));

    // backpressure
    bus.req_valid = '1; bus.rsp_ready = 1'b0;
    repeat (3) step("bp");
    bus.rsp_ready = 1'b1;
    step("bp_rel");
    post("bp_rel", 1, ref_f(2'd1, 8'h22, 8'h5A));

    // reset mid-operation with ptr=3
    bus.req_valid = 4'b0100;
    step("pre_rst");
    bus.req_valid = '1; rst = 1'b1;
    step("mid_rst");
    rst = 1'b0;
    step("post_rst");
    post("post_rst", 0, ref_f(2'd0, 8'h11, 8'h5A));

    // random traffic
    for (int n = 0; n < 400; n++) begin
      bus.req_valid = NREQ'($urandom);
      bus.req_op    = (2*NREQ)'($urandom);
      bus.req_a     = (W*NREQ)'($urandom);
      bus.req_b     = (W*NREQ)'($urandom);
      bus.rsp_ready = ($urandom_range(0, 9) < 7);
      rst           = ($urandom_range(0, 99) == 0);
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
